// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-control bundle between the hazard/stall sequencer and the MIPS datapath.
// The slave side is the sequencer; the master side is the pipeline that feeds it.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic             mem_access;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken,
           mem_access, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_bubble, err_timeout, stall_cnt, flush_cnt
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken,
           mem_access, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_bubble, err_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central sequencer for the 5-stage pipe: freezes on slow dmem, flushes on taken
// branches, inserts one bubble on load-use, and halts on a memory timeout.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic mem_hold;
  logic load_use;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble;
  logic flush_evt;

  assign mem_hold = bus.mem_access & ~bus.dmem_ready;
  assign load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    flush_evt    = 1'b0;
    if (rst) begin
      // defaults already describe the forced reset pattern
    end else if ((state_q == HALT) || mem_hold) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (bus.ex_branch_taken) begin
      // The ID instruction is squashed, so any load-use stall on it is moot.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_evt  = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    stall_d = stall_q;
    flush_d = flush_q;
    unique case (state_q)
      RUN: begin
        if (mem_hold) begin
          state_d = MEM_WAIT;
          wait_d  = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_hold) begin
          state_d = RUN;
          wait_d  = 16'd0;
        end else if (wait_q >= TIMEOUT_LIM) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    if (!pc_en && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (flush_evt && (flush_q != '1)) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_en      = idex_en;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.err_timeout  = err_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, branch priority, dmem wait,
// timeout/halt with counter saturation, and reset mid-wait.
module tb_hazard_stall_ctrl;

  localparam int unsigned CNT_W = 16;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}
  localparam logic [6:0] CTL_NONE   = 7'b1101010;
  localparam logic [6:0] CTL_HOLD   = 7'b0000001;
  localparam logic [6:0] CTL_BRANCH = 7'b1111110;
  localparam logic [6:0] CTL_LDUSE  = 7'b0001110;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] ctl;
  assign ctl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                bus.idex_flush, bus.exmem_en, bus.memwb_bubble};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.id_rs           = 5'd0;
    bus.id_rt           = 5'd0;
    bus.id_uses_rt      = 1'b0;
    bus.ex_memread      = 1'b0;
    bus.ex_rt           = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_access      = 1'b0;
    bus.dmem_ready      = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset overrides a pending memory hold and a taken branch.
    clear_in();
    rst = 1'b1;
    bus.mem_access      = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #1;
    check("rst_ctl_forced", 32'(ctl), 32'(CTL_NONE));
    tick();
    tick();
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    check("rst_err", 32'(bus.err_timeout), 32'd0);
    rst = 1'b0;
    clear_in();
    #1;
    check("idle_ctl", 32'(ctl), 32'(CTL_NONE));

    // Load-use on rs: exactly one stall cycle.
    bus.ex_memread = 1'b1;
    bus.ex_rt      = 5'd8;
    bus.id_rs      = 5'd8;
    #1;
    check("lduse_ctl", 32'(ctl), 32'(CTL_LDUSE));
    tick();
    clear_in();
    #1;
    check("lduse_release_ctl", 32'(ctl), 32'(CTL_NONE));
    check("lduse_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // No hazard on $zero, nor on rt when rt is not a source.
    do_reset();
    bus.ex_memread = 1'b1;
    bus.ex_rt      = 5'd0;
    bus.id_rs      = 5'd0;
    #1;
    check("zero_reg_ctl", 32'(ctl), 32'(CTL_NONE));
    tick();
    bus.ex_rt      = 5'd9;
    bus.id_rt      = 5'd9;
    bus.id_rs      = 5'd1;
    bus.id_uses_rt = 1'b0;
    #1;
    check("rt_unused_ctl", 32'(ctl), 32'(CTL_NONE));
    tick();
    check("no_hazard_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    bus.id_uses_rt = 1'b1;
    #1;
    check("rt_used_ctl", 32'(ctl), 32'(CTL_LDUSE));
    tick();
    clear_in();

    // Branch and load-use together: branch wins.
    do_reset();
    bus.ex_memread      = 1'b1;
    bus.ex_rt           = 5'd8;
    bus.id_rs           = 5'd8;
    bus.ex_branch_taken = 1'b1;
    #1;
    check("br_hazard_ctl", 32'(ctl), 32'(CTL_BRANCH));
    tick();
    clear_in();
    #1;
    check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // Three wait cycles, then a release cycle carrying a taken branch.
    do_reset();
    bus.mem_access = 1'b1;
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("memwait_ctl_%0d", i), 32'(ctl), 32'(CTL_HOLD));
      tick();
    end
    bus.dmem_ready      = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #1;
    check("memwait_release_ctl", 32'(ctl), 32'(CTL_BRANCH));
    tick();
    clear_in();
    #1;
    check("memwait_ctl_after", 32'(ctl), 32'(CTL_NONE));
    check("memwait_stall_cnt", 32'(bus.stall_cnt), 32'd3);
    check("memwait_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    check("memwait_err", 32'(bus.err_timeout), 32'd0);

    // Timeout with MEM_TIMEOUT = 4: error after the 5th wait cycle, then HALT.
    do_reset();
    bus.mem_access = 1'b1;
    bus.dmem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check($sformatf("tmo_err_pre_%0d", i), 32'(bus.err_timeout), 32'd0);
      tick();
    end
    check("tmo_err_set", 32'(bus.err_timeout), 32'd1);
    check("tmo_stall_cnt", 32'(bus.stall_cnt), 32'd5);
    clear_in();
    bus.ex_branch_taken = 1'b1;
    #1;
    check("halt_ctl", 32'(ctl), 32'(CTL_HOLD));
    repeat (65535) tick();
    check("halt_stall_sat", 32'(bus.stall_cnt), 32'h0000_FFFF);
    check("halt_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    check("halt_ctl_late", 32'(ctl), 32'(CTL_HOLD));
    do_reset();
    #1;
    check("tmo_rst_err", 32'(bus.err_timeout), 32'd0);
    check("tmo_rst_stall", 32'(bus.stall_cnt), 32'd0);
    check("tmo_rst_ctl", 32'(ctl), 32'(CTL_NONE));

    // Reset asserted on wait cycle 2.
    do_reset();
    bus.mem_access = 1'b1;
    bus.dmem_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rstwait_ctl_forced", 32'(ctl), 32'(CTL_NONE));
    tick();
    rst = 1'b0;
    bus.mem_access = 1'b0;
    #1;
    check("rstwait_ctl", 32'(ctl), 32'(CTL_NONE));
    check("rstwait_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rstwait_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    check("rstwait_err", 32'(bus.err_timeout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
